// File: rtl/battle_turn_sequencer.sv
// battle_turn_sequencer: two-player turn-based battle sequencer.
// Loads both fighters, collects one skill selection per player, resolves
// the faster player's hit and then the slower player's hit, each followed
// by a fixed animation window, and ends the battle once a player's HP is 0.
// Optional build macro: BATTLE_CRIT_EN adds LFSR-driven critical hits
// (double damage, saturating at 255). Without it damage is always exact.

module battle_turn_sequencer #(
    parameter int unsigned ANIM_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] p1_hp,
    input  logic [7:0] p2_hp,
    input  logic [7:0] p1_speed,
    input  logic [7:0] p2_speed,
    input  logic [7:0] p1_dmg1,
    input  logic [7:0] p1_dmg2,
    input  logic [7:0] p1_dmg3,
    input  logic [7:0] p2_dmg1,
    input  logic [7:0] p2_dmg2,
    input  logic [7:0] p2_dmg3,
    input  logic [1:0] p1_sel,
    input  logic [1:0] p2_sel,
    input  logic       p1_sel_valid,
    input  logic       p2_sel_valid,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic [3:0] state,
    output logic       attacker,
    output logic       anim_busy,
    output logic       to_end_scene,
    output logic       winner,
    output logic       crit
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_LOAD        = 4'd1,
        S_WAIT_SEL    = 4'd2,
        S_FIRST_HIT   = 4'd3,
        S_FIRST_ANIM  = 4'd4,
        S_SECOND_HIT  = 4'd5,
        S_SECOND_ANIM = 4'd6,
        S_CHECK       = 4'd7,
        S_END         = 4'd8
    } state_e;

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       p1_hp_q, p1_hp_d;
    logic [7:0]       p2_hp_q, p2_hp_d;
    logic [7:0]       p1_spd_q, p1_spd_d;
    logic [7:0]       p2_spd_q, p2_spd_d;
    logic [2:0][7:0]  p1_dmg_q, p1_dmg_d;
    logic [2:0][7:0]  p2_dmg_q, p2_dmg_d;
    logic [1:0]       p1_sel_q, p1_sel_d;
    logic [1:0]       p2_sel_q, p2_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             attacker_q, attacker_d;
    logic             winner_q, winner_d;
    logic             to_end_q, to_end_d;

    logic [7:0]       hit_dmg;
    logic [7:0]       eff_dmg;
    logic [7:0]       def_hp;
    logic [7:0]       hit_hp;
    logic             anim_done;

    // Skill index 1..3 picks a damage entry; 0 (no selection) deals nothing.
    function automatic logic [7:0] skill_dmg(input logic [1:0] sel, input logic [2:0][7:0] tbl);
        case (sel)
            2'd1:    skill_dmg = tbl[0];
            2'd2:    skill_dmg = tbl[1];
            2'd3:    skill_dmg = tbl[2];
            default: skill_dmg = 8'd0;
        endcase
    endfunction

    // attacker_q is updated on entry to each HIT, so it names the hitter in
    // HIT and the following ANIM; the defender is always the other player.
    assign hit_dmg   = attacker_q ? skill_dmg(p2_sel_q, p2_dmg_q) : skill_dmg(p1_sel_q, p1_dmg_q);
    assign def_hp    = attacker_q ? p1_hp_q : p2_hp_q;
    assign hit_hp    = (def_hp > eff_dmg) ? (def_hp - eff_dmg) : 8'd0;
    assign anim_done = (cnt_q == CNT_LAST);

`ifdef BATTLE_CRIT_EN
    logic [7:0] lfsr_q;
    logic       hit_crit;
    logic [8:0] dbl_dmg;
    logic       crit_q, crit_d;

    // Free-running maximal-length LFSR (x^8+x^6+x^5+x^4+1) used as the crit roll.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 8'h01;
        else      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign hit_crit = (lfsr_q[2:0] == 3'd0);
    assign dbl_dmg  = {hit_dmg, 1'b0};
    assign eff_dmg  = !hit_crit ? hit_dmg : (dbl_dmg[8] ? 8'hFF : dbl_dmg[7:0]);

    // crit is captured at the HIT and held for the whole following ANIM.
    always_comb begin
        crit_d = 1'b0;
        if (!abort) begin
            if (state_q == S_FIRST_HIT || state_q == S_SECOND_HIT)
                crit_d = hit_crit;
            else if ((state_q == S_FIRST_ANIM || state_q == S_SECOND_ANIM) && !anim_done)
                crit_d = crit_q;
        end
    end

    // Crit flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crit_q <= 1'b0;
        else      crit_q <= crit_d;
    end

    assign crit = crit_q;
`else
    assign eff_dmg = hit_dmg;
    assign crit    = 1'b0;
`endif

    // All sequencer state, cleared asynchronously so a mid-battle reset bites at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            p1_hp_q    <= 8'd0;
            p2_hp_q    <= 8'd0;
            p1_spd_q   <= 8'd0;
            p2_spd_q   <= 8'd0;
            p1_dmg_q   <= '0;
            p2_dmg_q   <= '0;
            p1_sel_q   <= 2'd0;
            p2_sel_q   <= 2'd0;
            cnt_q      <= '0;
            attacker_q <= 1'b0;
            winner_q   <= 1'b0;
            to_end_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            p1_hp_q    <= p1_hp_d;
            p2_hp_q    <= p2_hp_d;
            p1_spd_q   <= p1_spd_d;
            p2_spd_q   <= p2_spd_d;
            p1_dmg_q   <= p1_dmg_d;
            p2_dmg_q   <= p2_dmg_d;
            p1_sel_q   <= p1_sel_d;
            p2_sel_q   <= p2_sel_d;
            cnt_q      <= cnt_d;
            attacker_q <= attacker_d;
            winner_q   <= winner_d;
            to_end_q   <= to_end_d;
        end
    end

    // Next-state and datapath updates; abort overrides everything and keeps HP.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path infers a latch.
        state_d    = state_q;
        p1_hp_d    = p1_hp_q;
        p2_hp_d    = p2_hp_q;
        p1_spd_d   = p1_spd_q;
        p2_spd_d   = p2_spd_q;
        p1_dmg_d   = p1_dmg_q;
        p2_dmg_d   = p2_dmg_q;
        p1_sel_d   = p1_sel_q;
        p2_sel_d   = p2_sel_q;
        cnt_d      = cnt_q;
        attacker_d = attacker_q;
        winner_d   = winner_q;
        to_end_d   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    p1_hp_d  = p1_hp;
                    p2_hp_d  = p2_hp;
                    p1_spd_d = p1_speed;
                    p2_spd_d = p2_speed;
                    p1_dmg_d = {p1_dmg3, p1_dmg2, p1_dmg1};
                    p2_dmg_d = {p2_dmg3, p2_dmg2, p2_dmg1};
                    p1_sel_d = 2'd0;
                    p2_sel_d = 2'd0;
                    state_d  = S_WAIT_SEL;
                end
                S_WAIT_SEL: begin
                    if (p1_sel_valid && p1_sel != 2'd0) p1_sel_d = p1_sel;
                    if (p2_sel_valid && p2_sel != 2'd0) p2_sel_d = p2_sel;
                    // Leave as soon as both selections will be held; ties go to p1.
                    if (p1_sel_d != 2'd0 && p2_sel_d != 2'd0) begin
                        state_d    = S_FIRST_HIT;
                        attacker_d = (p2_spd_q > p1_spd_q);
                    end
                end
                S_FIRST_HIT, S_SECOND_HIT: begin
                    if (attacker_q) p1_hp_d = hit_hp;
                    else            p2_hp_d = hit_hp;
                    cnt_d   = '0;
                    state_d = (state_q == S_FIRST_HIT) ? S_FIRST_ANIM : S_SECOND_ANIM;
                end
                S_FIRST_ANIM: begin
                    if (anim_done) begin
                        if (def_hp == 8'd0) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d    = S_SECOND_HIT;
                            attacker_d = ~attacker_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SECOND_ANIM: begin
                    if (anim_done) state_d = S_CHECK;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
                S_CHECK: begin
                    if (p1_hp_q == 8'd0 || p2_hp_q == 8'd0) begin
                        state_d  = S_END;
                        to_end_d = 1'b1;
                        winner_d = (p1_hp_q == 8'd0);
                    end else begin
                        state_d  = S_WAIT_SEL;
                        p1_sel_d = 2'd0;
                        p2_sel_d = 2'd0;
                    end
                end
                S_END: begin
                    state_d = S_END;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign p1_cur_hp    = p1_hp_q;
    assign p2_cur_hp    = p2_hp_q;
    assign state        = state_q;
    assign attacker     = attacker_q;
    assign anim_busy    = (state_q == S_FIRST_ANIM) || (state_q == S_SECOND_ANIM);
    assign to_end_scene = to_end_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Bench for battle_turn_sequencer (ANIM_CYCLES=4, crit feature off).
// The reference model tracks each player's HP, speed, skill table and
// selection, and resolves a round as "faster hits first, slower hits back
// unless knocked out", with HP floored at zero.

module tb_battle_turn_sequencer;

    localparam int ANIM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] p1_hp, p2_hp, p1_speed, p2_speed;
    logic [7:0] p1_dmg1, p1_dmg2, p1_dmg3, p2_dmg1, p2_dmg2, p2_dmg3;
    logic [1:0] p1_sel, p2_sel;
    logic       p1_sel_valid, p2_sel_valid;
    logic [7:0] p1_cur_hp, p2_cur_hp;
    logic [3:0] state;
    logic       attacker, anim_busy, to_end_scene, winner, crit;

    int checks = 0;
    int errors = 0;

    // Reference model of the battle.
    int unsigned m_hp  [2];
    int unsigned m_spd [2];
    int unsigned m_dmg [2][4];
    int unsigned m_sel [2];

    battle_turn_sequencer #(.ANIM_CYCLES(ANIM)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .p1_hp        (p1_hp),
        .p2_hp        (p2_hp),
        .p1_speed     (p1_speed),
        .p2_speed     (p2_speed),
        .p1_dmg1      (p1_dmg1),
        .p1_dmg2      (p1_dmg2),
        .p1_dmg3      (p1_dmg3),
        .p2_dmg1      (p2_dmg1),
        .p2_dmg2      (p2_dmg2),
        .p2_dmg3      (p2_dmg3),
        .p1_sel       (p1_sel),
        .p2_sel       (p2_sel),
        .p1_sel_valid (p1_sel_valid),
        .p2_sel_valid (p2_sel_valid),
        .p1_cur_hp    (p1_cur_hp),
        .p2_cur_hp    (p2_cur_hp),
        .state        (state),
        .attacker     (attacker),
        .anim_busy    (anim_busy),
        .to_end_scene (to_end_scene),
        .winner       (winner),
        .crit         (crit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int unsigned sat_sub(input int unsigned hp, input int unsigned dmg);
        return (hp > dmg) ? hp - dmg : 0;
    endfunction

    task automatic check_hp(input string tag);
        check({tag, "_p1hp"}, p1_cur_hp, m_hp[0]);
        check({tag, "_p2hp"}, p2_cur_hp, m_hp[1]);
    endtask

    // From IDLE: present fighter data, pulse start, expect LOAD then WAIT_SEL.
    task automatic start_battle(input int unsigned h1, input int unsigned h2,
                                input int unsigned s1, input int unsigned s2,
                                input int unsigned a1, input int unsigned a2, input int unsigned a3,
                                input int unsigned b1, input int unsigned b2, input int unsigned b3);
        m_hp[0] = h1;  m_hp[1] = h2;
        m_spd[0] = s1; m_spd[1] = s2;
        m_dmg[0][1] = a1; m_dmg[0][2] = a2; m_dmg[0][3] = a3;
        m_dmg[1][1] = b1; m_dmg[1][2] = b2; m_dmg[1][3] = b3;
        m_sel[0] = 0; m_sel[1] = 0;
        p1_hp = 8'(h1); p2_hp = 8'(h2);
        p1_speed = 8'(s1); p2_speed = 8'(s2);
        p1_dmg1 = 8'(a1); p1_dmg2 = 8'(a2); p1_dmg3 = 8'(a3);
        p2_dmg1 = 8'(b1); p2_dmg2 = 8'(b2); p2_dmg3 = 8'(b3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_state", state, 1);
        tick();
        check("wait_state", state, 2);
        check_hp("load");
    endtask

    // One-cycle selection strobe(s) in WAIT_SEL; FIRST_HIT follows once both are held.
    task automatic strobe(input bit v1, input logic [1:0] s1, input bit v2, input logic [1:0] s2);
        p1_sel_valid = v1; p1_sel = s1;
        p2_sel_valid = v2; p2_sel = s2;
        if (v1 && s1 != 2'd0) m_sel[0] = s1;
        if (v2 && s2 != 2'd0) m_sel[1] = s2;
        tick();
        p1_sel_valid = 1'b0; p2_sel_valid = 1'b0;
        p1_sel = 2'd0; p2_sel = 2'd0;
        check("sel_state", state, (m_sel[0] != 0 && m_sel[1] != 0) ? 3 : 2);
    endtask

    task automatic count_anim(output int n);
        n = 0;
        while (anim_busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    // Called while in FIRST_HIT; follows the round to WAIT_SEL or END.
    task automatic run_round(output bit ended);
        int unsigned first, second;
        int n;
        first  = (m_spd[0] >= m_spd[1]) ? 0 : 1;
        second = 1 - first;
        check("hit1_state", state, 3);
        check("hit1_attacker", attacker, first);
        tick();
        m_hp[second] = sat_sub(m_hp[second], m_dmg[first][m_sel[first]]);
        check("anim1_state", state, 4);
        check("anim1_crit", crit, 0);
        check_hp("hit1");
        count_anim(n);
        check("anim1_len", n, ANIM);
        if (m_hp[second] == 0) begin
            check("ko_state", state, 7);
        end else begin
            check("hit2_state", state, 5);
            check("hit2_attacker", attacker, second);
            tick();
            m_hp[first] = sat_sub(m_hp[first], m_dmg[second][m_sel[second]]);
            check("anim2_state", state, 6);
            check_hp("hit2");
            count_anim(n);
            check("anim2_len", n, ANIM);
            check("check_state", state, 7);
        end
        tick();
        if (m_hp[0] == 0 || m_hp[1] == 0) begin
            ended = 1'b1;
            check("end_state", state, 8);
            check("end_pulse", to_end_scene, 1);
            check("winner", winner, (m_hp[0] == 0) ? 1 : 0);
            tick();
            check("end_pulse_once", to_end_scene, 0);
            check("end_hold_state", state, 8);
            check_hp("end");
        end else begin
            ended = 1'b0;
            check("back_to_wait", state, 2);
            m_sel[0] = 0; m_sel[1] = 0;
        end
    endtask

    task automatic abort_battle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", state, 0);
        check_hp("abort_hold");
    endtask

    // Directed steps, then randomized battles against the model.
    initial begin
        bit ended;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        p1_hp = '0; p2_hp = '0; p1_speed = '0; p2_speed = '0;
        p1_dmg1 = '0; p1_dmg2 = '0; p1_dmg3 = '0;
        p2_dmg1 = '0; p2_dmg2 = '0; p2_dmg3 = '0;
        p1_sel = '0; p2_sel = '0; p1_sel_valid = 1'b0; p2_sel_valid = 1'b0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_p1hp", p1_cur_hp, 0);
        check("rst_p2hp", p2_cur_hp, 0);
        check("rst_attacker", attacker, 0);
        check("rst_anim_busy", anim_busy, 0);
        check("rst_to_end", to_end_scene, 0);
        check("rst_winner", winner, 0);
        check("rst_crit", crit, 0);
        rst = 1'b1;
        tick();
        check("idle_after_release", state, 0);

        // Normal round: p1 faster, expects 100/80 -> 85/60.
        start_battle(100, 80, 50, 30, 20, 11, 7, 9, 15, 13);
        strobe(1, 2'd1, 1, 2'd2);
        run_round(ended);
        check("normal_p1hp", p1_cur_hp, 85);
        check("normal_p2hp", p2_cur_hp, 60);

        // Selection rules: sel=0 ignored, later strobe overwrites (skill 3 = 7).
        strobe(1, 2'd0, 0, 2'd0);
        strobe(1, 2'd1, 0, 2'd0);
        strobe(1, 2'd3, 0, 2'd0);
        strobe(0, 2'd0, 1, 2'd2);
        run_round(ended);
        check("overwrite_p2hp", p2_cur_hp, 53);
        abort_battle();

        // Speed tie goes to p1.
        start_battle(90, 90, 40, 40, 5, 6, 7, 8, 9, 10);
        strobe(1, 2'd2, 1, 2'd3);
        run_round(ended);
        abort_battle();

        // KO with saturation: p2 at 10 takes 30.
        start_battle(50, 10, 60, 20, 30, 1, 1, 40, 40, 40);
        strobe(1, 2'd1, 1, 2'd1);
        run_round(ended);
        check("ko_ended", ended, 1);
        check("ko_p1_unchanged", p1_cur_hp, 50);
        start = 1'b1; p1_sel_valid = 1'b1; p1_sel = 2'd2;
        tick();
        start = 1'b0; p1_sel_valid = 1'b0; p1_sel = 2'd0;
        check("end_ignores_start", state, 8);
        tick();
        check("end_still", state, 8);
        check_hp("end_ignore");
        abort_battle();

        // Asynchronous reset in the middle of FIRST_ANIM (p2 attacking).
        start_battle(120, 100, 10, 70, 3, 3, 3, 25, 25, 25);
        strobe(1, 2'd2, 1, 2'd3);
        tick();
        check("pre_rst_anim", state, 4);
        check("pre_rst_attacker", attacker, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_p1hp", p1_cur_hp, 0);
        check("arst_p2hp", p2_cur_hp, 0);
        check("arst_attacker", attacker, 0);
        check("arst_anim_busy", anim_busy, 0);
        check("arst_to_end", to_end_scene, 0);
        check("arst_winner", winner, 0);
        check("arst_crit", crit, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", state, 0);
        start_battle(77, 66, 5, 9, 12, 13, 14, 21, 22, 23);
        strobe(1, 2'd3, 1, 2'd1);
        run_round(ended);
        abort_battle();

        // Randomized battles.
        for (int b = 0; b < 8; b++) begin
            start_battle($urandom_range(1, 255), $urandom_range(1, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120),
                         $urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120));
            ended = 1'b0;
            for (int r = 0; r < 6 && !ended; r++) begin
                if ($urandom_range(0, 3) == 0) strobe(1, 2'd0, 1, 2'd0);
                if ($urandom_range(0, 1) == 1) begin
                    strobe(1, 2'($urandom_range(1, 3)), 1, 2'($urandom_range(1, 3)));
                end else begin
                    strobe(0, 2'd0, 1, 2'($urandom_range(1, 3)));
                    strobe(1, 2'($urandom_range(1, 3)), 0, 2'd0);
                end
                run_round(ended);
            end
            abort_battle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
